// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode/funct constants and the issue payload record
// used by the ID->EX issue stage.
package alu_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int CARD_W_DEF = 5;

   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_ADD   = 5'd1;
   localparam logic [4:0] OP_SLT   = 5'd2;
   localparam logic [4:0] OP_SUB   = 5'd3;
   localparam logic [4:0] OP_PASSA = 5'd7;
   localparam logic [4:0] OP_PASSB = 5'd8;
   localparam logic [4:0] OP_OR    = 5'd11;
   localparam logic [4:0] OP_AND   = 5'd12;
   localparam logic [4:0] OP_XOR   = 5'd13;
   localparam logic [4:0] OP_SLL   = 5'd16;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [4:0]  card;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational RV32I -> ALU decode: op code, operands, destination and
// writeback enable. Unsupported encodings become a NOP with illegal set.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output issue_t      dec
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};

   always_comb begin
      dec         = '0;
      dec.rd      = instr[11:7];
      dec.illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec.a = rs1_data;
            dec.b = rs2_data;
            if (f7 == F7_ALT && f3 == F3_ADD) begin
               dec.card = OP_SUB;
            end else if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  dec.card = OP_ADD;
                  F3_SLL:  dec.card = OP_SLL;
                  F3_SLT:  dec.card = OP_SLT;
                  F3_XOR:  dec.card = OP_XOR;
                  F3_OR:   dec.card = OP_OR;
                  F3_AND:  dec.card = OP_AND;
                  default: dec.illegal = 1'b1;
               endcase
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec.a = rs1_data;
            dec.b = imm_i;
            case (f3)
               F3_ADD: dec.card = OP_ADD;
               F3_SLT: dec.card = OP_SLT;
               F3_XOR: dec.card = OP_XOR;
               F3_OR:  dec.card = OP_OR;
               F3_AND: dec.card = OP_AND;
               F3_SLL: begin
                  // Only a plain shift amount is accepted; upper imm bits must be clear
                  if (f7 == F7_BASE) begin
                     dec.card = OP_SLL;
                     dec.b    = {27'b0, instr[24:20]};
                  end else begin
                     dec.illegal = 1'b1;
                  end
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec.card = OP_PASSB;
            dec.b    = imm_u;
         end
         OPC_AUIPC: begin
            dec.card = OP_ADD;
            dec.a    = pc;
            dec.b    = imm_u;
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) begin
         dec.card = OP_NOP;
         dec.a    = '0;
         dec.b    = '0;
      end
      dec.we = ~dec.illegal & (dec.rd != 5'd0);
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode then a 2-entry skid buffer so in_ready is a flop
// and EX back-pressure never reaches ID combinationally.
//
// state | meaning
// EMPTY | no entries; in_ready=1, out_valid=0
// ONE   | head valid; in_ready=1, out_valid=1
// FULL  | head and skid valid; in_ready=0, out_valid=1
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int CARD_W = CARD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CARD_W-1:0] out_card,
   output logic [XLEN-1:0]   out_a,
   output logic [XLEN-1:0]   out_b,
   output logic              out_cin,
   output logic [4:0]        out_rd,
   output logic              out_we,
   output logic              out_illegal
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_t;

   occ_t   state;
   issue_t dec;
   issue_t head;
   issue_t skid;
   logic   acc;
   logic   drn;

   alu_op_decode u_decode (
      .instr    (in_instr),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .dec      (dec)
   );

   assign acc = in_valid & in_ready;
   assign drn = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         head      <= '0;
         skid      <= '0;
      end else if (flush) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  head      <= dec;
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && !drn) begin
                  skid     <= dec;
                  state    <= ST_FULL;
                  in_ready <= 1'b0;
               end else if (!acc && drn) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end else if (acc && drn) begin
                  head <= dec;
               end
            end
            ST_FULL: begin
               if (drn) begin
                  head     <= skid;
                  state    <= ST_ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_card    = head.card;
   assign out_a       = head.a;
   assign out_b       = head.b;
   assign out_rd      = head.rd;
   assign out_we      = head.we;
   assign out_illegal = head.illegal;
   assign out_cin     = 1'b0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode table, back-pressure
// and flush sequences, then random traffic against a queue-based reference.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_card;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic        out_cin;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_card    (out_card),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_cin     (out_cin),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_illegal (out_illegal)
   );

   typedef struct {
      logic [4:0]  card;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      exp_t        e;
   } vec_t;

   // Reference decode built from the instruction-set rules directly
   function automatic exp_t model(logic [31:0] ins, logic [31:0] pc,
                                  logic [31:0] r1, logic [31:0] r2);
      exp_t        e;
      int          op_card [8] = '{1, 16, 2, -1, 13, -1, 11, 12};
      logic [6:0]  opc = ins[6:0];
      int          f3  = int'(ins[14:12]);
      int          f7  = int'(ins[31:25]);
      logic [31:0] upper = ins & 32'hFFFF_F000;
      bit          ok = 1'b1;
      e.rd = ins[11:7];
      e.a  = 0;
      e.b  = 0;
      e.card = 0;
      if (opc == 7'h33) begin
         e.a = r1;
         e.b = r2;
         if (f7 == 32 && f3 == 0) e.card = 3;
         else if (f7 == 0 && op_card[f3] >= 0) e.card = 5'(op_card[f3]);
         else ok = 1'b0;
      end else if (opc == 7'h13) begin
         e.a = r1;
         e.b = 32'($signed(ins) >>> 20);
         if (f3 == 1) begin
            if (f7 == 0) begin
               e.card = 16;
               e.b    = (ins >> 20) % 32;
            end else ok = 1'b0;
         end else if (op_card[f3] >= 0) e.card = 5'(op_card[f3]);
         else ok = 1'b0;
      end else if (opc == 7'h37) begin
         e.card = 8;
         e.b    = upper;
      end else if (opc == 7'h17) begin
         e.card = 1;
         e.a    = pc;
         e.b    = upper;
      end else ok = 1'b0;
      if (!ok) begin
         e.card = 0;
         e.a    = 0;
         e.b    = 0;
      end
      e.ill = !ok;
      e.we  = ok && (e.rd != 0);
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(string tag, exp_t e);
      chk({tag, ".valid"},   32'(out_valid),   32'd1);
      chk({tag, ".card"},    32'(out_card),    32'(e.card));
      chk({tag, ".a"},       out_a,            e.a);
      chk({tag, ".b"},       out_b,            e.b);
      chk({tag, ".we"},      32'(out_we),      32'(e.we));
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
      chk({tag, ".cin"},     32'(out_cin),     32'd0);
      if (!e.ill) chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
   endtask

   task automatic drive(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2);
      in_valid    = 1'b1;
      in_instr    = ins;
      in_pc       = pc;
      in_rs1_data = r1;
      in_rs2_data = r2;
   endtask

   function automatic vec_t mk(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                               logic [4:0] card, logic [31:0] a, logic [31:0] b,
                               logic [4:0] rd, logic we, logic ill);
      vec_t v;
      v.instr = ins; v.pc = pc; v.rs1 = r1; v.rs2 = r2;
      v.e.card = card; v.e.a = a; v.e.b = b; v.e.rd = rd; v.e.we = we; v.e.ill = ill;
      return v;
   endfunction

   vec_t vecs [$];
   exp_t q [$];
   exp_t e1, e2, e3;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      in_rs1_data = '0; in_rs2_data = '0; flush = 1'b0; out_ready = 1'b1;

      vecs.push_back(mk(32'h002081B3, 0, 5, 7,          1, 5, 7, 3, 1, 0));
      vecs.push_back(mk(32'h402081B3, 0, 10, 3,         3, 10, 3, 3, 1, 0));
      vecs.push_back(mk(32'hFFF00093, 0, 0, 9,          1, 0, 32'hFFFF_FFFF, 1, 1, 0));
      vecs.push_back(mk(32'h00429293, 0, 32'h11, 0,     16, 32'h11, 4, 5, 1, 0));
      vecs.push_back(mk(32'h123453B7, 0, 1, 2,          8, 0, 32'h1234_5000, 7, 1, 0));
      vecs.push_back(mk(32'h00001017, 32'h100, 1, 2,    1, 32'h100, 32'h1000, 0, 0, 0));
      vecs.push_back(mk(32'h0020B1B3, 0, 1, 2,          0, 0, 0, 3, 0, 1));
      vecs.push_back(mk(32'h00208063, 0, 1, 2,          0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h0020C233, 0, 32'hF0, 32'h0F, 13, 32'hF0, 32'h0F, 4, 1, 0));
      vecs.push_back(mk(32'h0020E233, 0, 6, 9,          11, 6, 9, 4, 1, 0));
      vecs.push_back(mk(32'h0020F233, 0, 6, 9,          12, 6, 9, 4, 1, 0));
      vecs.push_back(mk(32'h0020A233, 0, 6, 9,          2, 6, 9, 4, 1, 0));
      vecs.push_back(mk(32'h40429293, 0, 5, 5,          0, 0, 0, 5, 0, 1));
      vecs.push_back(mk(32'h022081B3, 0, 5, 7,          0, 0, 0, 3, 0, 1));
      vecs.push_back(mk(32'hFFF0C213, 0, 32'h55, 0,     13, 32'h55, 32'hFFFF_FFFF, 4, 1, 0));

      #12;
      chk("rst.in_ready",  32'(in_ready),    32'd1);
      chk("rst.out_valid", 32'(out_valid),   32'd0);
      chk("rst.card",      32'(out_card),    32'd0);
      chk("rst.a",         out_a,            32'd0);
      chk("rst.b",         out_b,            32'd0);
      chk("rst.cin",       32'(out_cin),     32'd0);
      chk("rst.rd",        32'(out_rd),      32'd0);
      chk("rst.we",        32'(out_we),      32'd0);
      chk("rst.illegal",   32'(out_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed decode table, streamed back to back with out_ready=1
      for (int i = 0; i <= vecs.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk_out($sformatf("tbl%0d", i - 1), vecs[i-1].e);
            chk("tbl.in_ready", 32'(in_ready), 32'd1);
         end
         if (i < vecs.size()) drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
         else in_valid = 1'b0;
      end
      @(negedge clk);
      chk("tbl.drained", 32'(out_valid), 32'd0);

      // Back-pressure: three pushes with EX stalled
      e1 = model(32'h002081B3, 0, 1, 2);
      e2 = model(32'h402081B3, 0, 3, 4);
      e3 = model(32'h123453B7, 0, 0, 0);
      out_ready = 1'b0;
      drive(32'h002081B3, 0, 1, 2);
      @(negedge clk);
      chk("bp.ready1", 32'(in_ready), 32'd1);
      chk_out("bp.i1a", e1);
      drive(32'h402081B3, 0, 3, 4);
      @(negedge clk);
      chk("bp.ready_full", 32'(in_ready), 32'd0);
      chk_out("bp.i1b", e1);
      drive(32'h123453B7, 0, 0, 0);
      @(negedge clk);
      chk("bp.ready_hold", 32'(in_ready), 32'd0);
      chk_out("bp.i1c", e1);
      out_ready = 1'b1;
      @(negedge clk);
      chk_out("bp.i2", e2);
      chk("bp.ready_back", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk_out("bp.i3", e3);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp.empty", 32'(out_valid), 32'd0);

      // Flush from FULL with an input offered
      out_ready = 1'b0;
      drive(32'h002081B3, 0, 1, 1);
      @(negedge clk);
      drive(32'h002081B3, 0, 2, 2);
      @(negedge clk);
      chk("fl.full", 32'(in_ready), 32'd0);
      flush = 1'b1;
      drive(32'h0020E233, 0, 3, 3);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl.out_valid", 32'(out_valid), 32'd0);
      chk("fl.in_ready",  32'(in_ready),  32'd1);
      // Flush from ONE, where the offered input would otherwise be accepted
      drive(32'h002081B3, 0, 4, 4);
      @(negedge clk);
      flush = 1'b1;
      drive(32'h0020F233, 0, 5, 5);
      @(negedge clk);
      flush = 1'b0;
      chk("fl1.out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      drive(32'h0020C233, 0, 6, 7);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("fl.next", model(32'h0020C233, 0, 6, 7));
      @(negedge clk);
      chk("fl.empty", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of a cycle with entries buffered
      out_ready = 1'b0;
      drive(32'h002081B3, 0, 8, 8);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.in_ready",  32'(in_ready),  32'd1);
      chk("arst.card",      32'(out_card),  32'd0);
      chk("arst.a",         out_a,          32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the queue reference
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] ins;
         logic [6:0]  opcs [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h03};
         bit          room;
         @(negedge clk);
         chk("rnd.in_ready",  32'(in_ready),  32'(q.size() < 2));
         chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0 && out_valid) chk_out("rnd", q[0]);
         ins = $urandom;
         if ($urandom_range(0, 7) != 0) ins[6:0] = opcs[$urandom_range(0, 5)];
         case ($urandom_range(0, 3))
            0, 1: ins[31:25] = 7'h00;
            2:    ins[31:25] = 7'h20;
            default: ;
         endcase
         drive(ins, $urandom, $urandom, $urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         room = (q.size() < 2);
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (flush) q.delete();
         else if (in_valid && room) q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
      end
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID→EX issue stage: decodes an RV32I instruction into the 5-bit ALU operation code (Card) plus operands A, B and Cin for the EX-stage ALU, then registers the result.
- Producer end of the ALU interface. The ALU consumes Card/A/B/Cin; this block generates them.
- Contains a 2-entry skid buffer with valid/ready handshake on both sides, so in_ready is a register output and back-pressure from EX never creates a combinational path to ID.

Parameters:
- XLEN, 32, datapath width of A, B and instruction/PC.
- CARD_W, 5, width of the ALU op code.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept (registered)
- in_instr  in  XLEN  raw instruction
- in_pc  in  XLEN  instruction PC
- in_rs1_data  in  XLEN  forwarded rs1 value
- in_rs2_data  in  XLEN  forwarded rs2 value
- flush  in  1  kill all buffered entries (branch/exception)
- out_valid  out  1  EX-side entry valid
- out_ready  in  1  EX accepts
- out_card  out  CARD_W  ALU op code
- out_a  out  XLEN  ALU operand A
- out_b  out  XLEN  ALU operand B
- out_cin  out  1  ALU carry-in (always 0 for RV32I)
- out_rd  out  5  destination register
- out_we  out  1  register writeback enable
- out_illegal  out  1  instruction not supported by ALU

Behaviour:
- Reset (async, rst_n=0):
  - State EMPTY; in_ready=1, out_valid=0.
  - out_card=0, out_a=0, out_b=0, out_cin=0, out_rd=0, out_we=0, out_illegal=0.
- Card encoding (shared constants): ADD=1, SLT=2, SUB=3, PASSA=7, PASSB=8, OR=11, AND=12, XOR=13, SLL=16, NOP=0.
- Decode (combinational, before the buffer), by opcode in_instr[6:0]:
  - 0110011 OP: A=rs1, B=rs2.
    - f3=000: f7=0000000 → ADD; f7=0100000 → SUB.
    - f3=001 → SLL; 010 → SLT; 100 → XOR; 110 → OR; 111 → AND.
    - f3 011/101, or any other f7 → illegal.
  - 0010011 OP-IMM: A=rs1, B=sign-extended imm[31:20].
    - f3 000 → ADD; 010 → SLT; 100 → XOR; 110 → OR; 111 → AND.
    - f3 001 → SLL, only if imm[31:25]=0; then B={27'b0, instr[24:20]}.
    - Anything else → illegal.
  - 0110111 LUI: Card PASSB, B={instr[31:12],12'b0}, A=0.
  - 0010111 AUIPC: Card ADD, A=in_pc, B={instr[31:12],12'b0}.
  - Other opcodes → illegal.
- Illegal instructions: card=NOP, we=0, illegal=1, A=B=0; they still occupy a slot and are delivered.
- we = ~illegal & (rd!=0); out_cin=0 always.
- Transfers:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Latency 1 cycle: an instruction accepted at edge N appears at out_* after edge N when the buffer was empty.
- State machine (occupancy):
  - EMPTY: in_ready=1, out_valid=0. Accept → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept without drain → FULL (second entry goes to the skid slot).
    - Drain without accept → EMPTY.
    - Accept and drain in the same cycle → ONE; the new entry becomes the head.
  - FULL: in_ready=0, out_valid=1. Drain → ONE; the skid entry moves to the head.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_* hold stable while out_valid=1 & out_ready=0.
- flush (synchronous, highest priority):
  - Next state EMPTY and out_valid=0; in_ready=1 the next cycle.
  - An input offered in the flush cycle is discarded.
  - Any output transfer in the flush cycle still counts as completed.
- Reset mid-operation: all entries are lost immediately; outputs go to reset values asynchronously.

Decomposition:
- Package alu_pkg: Card constants (OP_ADD … OP_SLL, OP_NOP), RV32I opcode constants, funct3/funct7 constants.
- One sub-module, alu_op_decode (pure combinational decode: instr, pc, rs1, rs2 → card, a, b, rd, we, illegal).
- The top level holds the 2-entry skid buffer and the FSM.

Test Plan:
- Reset then `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_card=1, a=5, b=7, rd=3, we=1, illegal=0.
- `sub` (0x402081B3), rs1=10, rs2=3 → card=3. `addi x1,x0,-1` (0xFFF00093) → card=1, b=0xFFFFFFFF. `slli x5,x5,4` (0x00429293) → card=16, b=4.
- `lui x7,0x12345` → card=8, b=0x12345000, we=1. `auipc x0,1` at pc=0x100 → card=1, a=0x100, b=0x1000, we=0.
- `sltu` (f3=011) and opcode 0x63 → card=0, illegal=1, we=0, still delivered in order.
- Hold out_ready=0 and push 3 instructions → in_ready falls after 2 accepted, out_* stable. Release → outputs I1 then I2 in order; third accepted once in_ready=1.
- FULL state, then assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input absent from the output stream.
